// File: rtl/instr_loader.sv
// instr_loader: streams host words into instruction memory, holding the CPU in reset until the load completes.
module instr_loader #(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [5:0]  len_i,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        we_o,
    output logic [31:0] waddr_o,
    output logic [31:0] wdata_o,
    output logic        cpu_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    localparam int CW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    len_q, len_d;
    logic          err_q, err_d, we_q, done_q;
    logic [31:0]   waddr_q, wdata_q;
    logic          hs, last, legal, can_start;
    assign hs        = valid_i && state_q == LOAD;
    assign last      = 32'(cnt_q) + 32'd1 == 32'(len_q);
    assign legal     = len_i != 6'd0 && 32'(len_i) <= 32'(MEM_WORDS);
    assign can_start = start_i && (state_q == IDLE || state_q == RUN);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        err_d   = err_q;
        if (can_start) begin
            state_d = legal ? LOAD : state_q;
            cnt_d   = legal ? '0 : cnt_q;
            len_d   = legal ? len_i : len_q;
            err_d   = !legal;
        end
        if (hs) begin
            cnt_d   = last ? cnt_q : cnt_q + CW'(1);
            state_d = last ? DRAIN : LOAD;
        end
        if (state_q == DRAIN) state_d = RUN;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
            we_q    <= hs;
            done_q  <= state_q == DRAIN;
            if (hs) begin
                waddr_q <= 32'({cnt_q, 2'b00});
                wdata_q <= data_i;
            end
        end
    end
    assign ready_o   = state_q == LOAD;
    assign busy_o    = state_q == LOAD || state_q == DRAIN;
    assign cpu_rst_o = state_q == RUN;
    assign we_o      = we_q;
    assign waddr_o   = waddr_q;
    assign wdata_o   = wdata_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed and random loads checked against a word-count reference model.
module tb_instr_loader;
    logic        clk_i = 1'b0;
    logic        rst_i, start_i, valid_i;
    logic [5:0]  len_i;
    logic [31:0] data_i;
    logic        ready_o, we_o, cpu_rst_o, busy_o, done_o, err_o;
    logic [31:0] waddr_o, wdata_o;
    int          checks = 0, errors = 0;
    int          m_left, m_idx, n_we;
    bit          m_drain, m_cpu, m_done, m_we, m_err;
    logic [31:0] m_addr, m_data, max_wa;
    instr_loader #(.MEM_WORDS(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o), .we_o(we_o),
        .waddr_o(waddr_o), .wdata_o(wdata_o), .cpu_rst_o(cpu_rst_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic cyc(input logic r, input logic s, input logic [5:0] l, input logic v, input logic [31:0] d);
        bit hs, free;
        rst_i = r; start_i = s; len_i = l; valid_i = v; data_i = d;
        @(posedge clk_i);
        if (!r) begin
            m_left = 0; m_idx = 0; m_drain = 0; m_cpu = 0; m_done = 0;
            m_we = 0; m_err = 0; m_addr = 0; m_data = 0;
        end else begin
            hs     = v && m_left > 0;
            free   = m_left == 0 && !m_drain;
            m_done = m_drain;
            if (m_drain) begin
                m_drain = 0;
                m_cpu   = 1;
            end
            m_we = hs;
            if (hs) begin
                m_addr = 32'(m_idx * 4);
                m_data = d;
                m_idx++;
                m_left--;
                if (m_left == 0) m_drain = 1;
            end
            if (s && free) begin
                if (l >= 1 && l <= 32) begin
                    m_left = int'(l); m_idx = 0; m_err = 0; m_cpu = 0;
                end else m_err = 1;
            end
        end
        #1;
        chk("ready", {31'b0, ready_o}, {31'b0, m_left > 0});
        chk("busy", {31'b0, busy_o}, {31'b0, m_left > 0 || m_drain});
        chk("cpu_rst", {31'b0, cpu_rst_o}, {31'b0, m_cpu});
        chk("done", {31'b0, done_o}, {31'b0, m_done});
        chk("err", {31'b0, err_o}, {31'b0, m_err});
        chk("we", {31'b0, we_o}, {31'b0, m_we});
        chk("waddr", waddr_o, m_addr);
        chk("wdata", wdata_o, m_data);
        if (we_o === 1'b1) begin
            n_we++;
            if (waddr_o > max_wa) max_wa = waddr_o;
        end
    endtask
    initial begin
        max_wa = 0;
        n_we = 0;
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 3, 0, 0);
        cyc(1, 0, 0, 1, 32'hA0A0A0A0);
        cyc(1, 0, 0, 1, 32'hB1B1B1B1);
        cyc(1, 0, 0, 1, 32'hC2C2C2C2);
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 2, 0, 0);
        cyc(1, 0, 0, 1, 32'h11111111);
        cyc(1, 0, 0, 0, 32'hDEADBEEF);
        cyc(1, 0, 0, 0, 32'hDEADBEEF);
        cyc(1, 0, 0, 1, 32'h22222222);
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 0);
        cyc(1, 1, 33, 1, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 0, 0, 1, 32'h33333333);
        repeat (3) cyc(1, 0, 0, 0, 0);
        n_we = 0;
        cyc(1, 1, 32, 0, 0);
        for (int i = 0; i < 32; i++) cyc(1, 0, 0, 1, $urandom);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        chk("full_writes", n_we, 32);
        chk("max_waddr", max_wa, 32'h7C);
        cyc(1, 1, 5, 0, 0);
        cyc(1, 0, 0, 1, 32'h44444444);
        cyc(1, 0, 0, 1, 32'h55555555);
        cyc(0, 0, 0, 1, 32'h66666666);
        cyc(1, 0, 0, 1, 32'h77777777);
        cyc(1, 1, 2, 0, 0);
        cyc(1, 0, 0, 1, 32'h88888888);
        cyc(1, 0, 0, 1, 32'h99999999);
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(1, 0, 0, 1, 32'hAAAA5555);
        repeat (3) cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 15) == 0,
                6'($urandom_range(0, 36)), $urandom_range(0, 3) != 0, $urandom);
        chk("max_waddr_end", max_wa, 32'h7C);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
